// File: rtl/maj_bist_if.sv
// maj_bist_if: run control, cell stimulus/response and result bundle
// between a majority BIST controller and its host/cell side.
interface maj_bist_if #(
  parameter int N     = 59,
  parameter int VW    = 64,
  parameter int ERR_W = 16
);
  logic             start;
  logic             mode;
  logic [63:0]      seed;
  logic [VW-1:0]    num_vectors;
  logic [N-1:0]     x_out;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [N-1:0]     first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, mode, seed, num_vectors, dut_y,
    input  x_out, busy, done, pass, err_count,
    input  first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, mode, seed, num_vectors, dut_y,
    output x_out, busy, done, pass, err_count,
    output first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/maj_bist_ctrl.sv
// maj_bist_ctrl: drives vectors into an N-input majority cell and checks
// it against popcount >= THRESH. Define MAJ_BIST_LFSR_EN for LFSR mode.
module maj_bist_ctrl #(
  parameter int N          = 59,
  parameter int THRESH     = (N + 1) / 2,
  parameter int VW         = 64,
  parameter int ERR_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input logic       clk,
  input logic       rst_n,
  maj_bist_if.slave bus
);
  localparam int PW = $clog2(N + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, SETTLE, CHECK, DONE
  } state_t;

  state_t           state;
  logic [7:0]       set_cnt;
  logic [VW-1:0]    idx_q;
  logic [VW-1:0]    nv_q;
  logic [N-1:0]     x_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [N-1:0]     ffv_q;
  logic             ffval_q;

  logic [PW-1:0]    ones;
  logic             ref_y;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;
  logic [VW-1:0]    idx_nxt;
  logic [N-1:0]     x_first;
  logic [N-1:0]     x_next;
  logic             accept;
  logic             check_go;

  assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;
  assign check_go = (state == CHECK);

  // reference: popcount of the applied vector against the threshold
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++)
      ones = ones + PW'(x_q[i]);
  end

  assign ref_y    = (int'(ones) >= THRESH);
  assign mismatch = (bus.dut_y != ref_y);
  assign err_nxt  = (mismatch && (err_q != ERR_MAX))
                  ? err_q + ERR_W'(1) : err_q;
  assign idx_nxt  = idx_q + VW'(1);

`ifdef MAJ_BIST_LFSR_EN
  logic        mode_q;
  logic [63:0] lfsr_q;
  logic [63:0] seed_nz;
  logic [63:0] lfsr_step;

  assign seed_nz   = (bus.seed == '0) ? 64'd1 : bus.seed;
  assign lfsr_step = {lfsr_q[62:0],
                      lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign x_first   = bus.mode ? seed_nz[N-1:0] : '0;
  assign x_next    = mode_q ? lfsr_step[N-1:0] : x_q + N'(1);

  // pattern LFSR: seeded on accepted start, one step per check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      lfsr_q <= 64'd1;
    end else if (accept) begin
      mode_q <= bus.mode;
      lfsr_q <= seed_nz;
    end else if (check_go) begin
      lfsr_q <= lfsr_step;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.mode, bus.seed, check_go};
  assign x_first    = '0;
  assign x_next     = x_q + N'(1);
`endif

  // run sequencer: launch, settle, check, accumulate results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      set_cnt <= '0;
      idx_q   <= '0;
      nv_q    <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            nv_q    <= bus.num_vectors;
            idx_q   <= '0;
            x_q     <= x_first;
            busy_q  <= (bus.num_vectors != '0);
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (nv_q == '0) begin
            done_q <= 1'b1;
            pass_q <= 1'b1;
            state  <= DONE;
          end else begin
            set_cnt <= '0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (set_cnt == SET_LAST)
            state <= CHECK;
          else
            set_cnt <= set_cnt + 8'd1;
        end
        CHECK: begin
          err_q <= err_nxt;
          if (mismatch && !ffval_q) begin
            ffv_q   <= x_q;
            ffval_q <= 1'b1;
          end
          idx_q <= idx_nxt;
          if (idx_nxt == nv_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_nxt == '0);
            state  <= DONE;
          end else begin
            x_q     <= x_next;
            set_cnt <= '0;
            state   <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_out            = x_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffval_q;

endmodule

// File: tb/tb_maj_bist_ctrl.sv
// tb_maj_bist_ctrl: directed runs of maj_bist_ctrl (N=5, ERR_W=3)
// against a cycle-offset model of the run; MAJ_BIST_LFSR_EN aware.
`timescale 1ns/1ps
module tb_maj_bist_ctrl;
  localparam int N      = 5;
  localparam int THRESH = 3;
  localparam int ERR_W  = 3;
  localparam int S      = 2;
  localparam int S1     = S + 1;
  localparam int EMAX   = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  bit          m_active;
  int          m_t0;
  int          m_v;
  int          m_f;
  bit          m_mode;
  logic [63:0] m_seed;

  maj_bist_if #(.N(N), .VW(64), .ERR_W(ERR_W)) bus ();

  maj_bist_ctrl #(
    .N(N), .THRESH(THRESH), .VW(64),
    .ERR_W(ERR_W), .SETTLE_CYC(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit maj_ref(logic [N-1:0] v);
    return $countones(v) >= THRESH;
  endfunction

  // f: 0 = good cell, 1 = stuck-at-0, 2 = stuck-at-1
  function automatic bit cell_y(logic [N-1:0] v, int f);
    if (f == 1) return 1'b0;
    if (f == 2) return 1'b1;
    return maj_ref(v);
  endfunction

  assign bus.dut_y = cell_y(bus.x_out, m_f);

  function automatic logic [N-1:0] vec(int j);
    logic [63:0] l;
`ifdef MAJ_BIST_LFSR_EN
    if (m_mode) begin
      l = (m_seed == 64'd0) ? 64'd1 : m_seed;
      for (int i = 0; i < j; i++)
        l = {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
      return l[N-1:0];
    end
`endif
    l = 64'(j);
    return l[N-1:0];
  endfunction

  function automatic void model(
    output logic [N-1:0] ex, output bit eb, output bit ed,
    output bit ep, output int ee, output logic [N-1:0] ef,
    output bit efv);
    int k, fin, nchk, j, nerr;
    ex = '0; eb = 0; ed = 0; ep = 0;
    ee = 0; ef = '0; efv = 0;
    if (!m_active) return;
    k = cyc - m_t0;
    if (m_v == 0) begin
      ex = vec(0);
      ed = (k >= 1);
      ep = ed;
      return;
    end
    fin  = 1 + S1 * m_v;
    eb   = (k < fin);
    ed   = !eb;
    nchk = (k < 1) ? 0 : (k - 1) / S1;
    if (nchk > m_v) nchk = m_v;
    j = (k < 1) ? 0 : (k - 1) / S1;
    if (j > m_v - 1) j = m_v - 1;
    ex   = vec(j);
    nerr = 0;
    for (int i = 0; i < nchk; i++) begin
      if (cell_y(vec(i), m_f) != maj_ref(vec(i))) begin
        if (!efv) begin
          efv = 1;
          ef  = vec(i);
        end
        nerr++;
      end
    end
    ee = (nerr > EMAX) ? EMAX : nerr;
    ep = ed && (nerr == 0);
  endfunction

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endfunction

  // per-cycle comparison of every output against the run model
  always @(negedge clk) begin
    logic [N-1:0] ex, ef;
    bit eb, ed, ep, efv;
    int ee;
    if (chk_en) begin
      model(ex, eb, ed, ep, ee, ef, efv);
      chk("x_out", 64'(bus.x_out), 64'(ex));
      chk("busy", 64'(bus.busy), 64'(eb));
      chk("done", 64'(bus.done), 64'(ed));
      chk("pass", 64'(bus.pass), 64'(ep));
      chk("err_count", 64'(bus.err_count), 64'(ee));
      chk("ff_vec", 64'(bus.first_fail_vec), 64'(ef));
      chk("ff_valid", 64'(bus.first_fail_valid), 64'(efv));
    end
  end

  task automatic launch(input int v, input int f,
                        input bit md, input logic [63:0] sd);
    @(negedge clk);
    #2;
    bus.num_vectors = 64'(v);
    bus.mode        = md;
    bus.seed        = sd;
    bus.start       = 1'b1;
    m_v      = v;
    m_f      = f;
    m_mode   = md;
    m_seed   = sd;
    m_t0     = cyc + 1;
    m_active = 1'b1;
    @(negedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  task automatic poke_start();
    @(negedge clk);
    #2;
    bus.start = 1'b1;
    @(negedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_k(input int kk);
    int i;
    i = 0;
    while ((cyc - m_t0) != kk && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("wait_k", 64'(cyc - m_t0), 64'(kk));
  endtask

  task automatic wait_done(input int limit, output int k);
    k = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done) begin
        k = cyc - m_t0;
        break;
      end
    end
    if (k < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done in %0d cycles", limit);
    end
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_x"}, 64'(bus.x_out), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
    chk({nm, "_done"}, 64'(bus.done), 64'd0);
    chk({nm, "_pass"}, 64'(bus.pass), 64'd0);
    chk({nm, "_err"}, 64'(bus.err_count), 64'd0);
    chk({nm, "_ffv"}, 64'(bus.first_fail_vec), 64'd0);
    chk({nm, "_ffval"}, 64'(bus.first_fail_valid), 64'd0);
  endtask

  initial begin
    int k;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.mode        = 1'b0;
    bus.seed        = 64'd0;
    bus.num_vectors = 64'd0;
    m_active = 1'b0;
    m_f      = 0;
    m_v      = 0;
    m_t0     = 0;
    m_mode   = 1'b0;
    m_seed   = 64'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    launch(32, 0, 1'b0, 64'd0);
    wait_done(500, k);
    chk("good32_lat", 64'(k), 64'd97);
    chk("good32_pass", 64'(bus.pass), 64'd1);
    chk("good32_err", 64'(bus.err_count), 64'd0);
    chk("good32_ffval", 64'(bus.first_fail_valid), 64'd0);

    launch(32, 1, 1'b0, 64'd0);
    wait_done(500, k);
    chk("sa0_err", 64'(bus.err_count), 64'd7);
    chk("sa0_ffv", 64'(bus.first_fail_vec), 64'h07);
    chk("sa0_ffval", 64'(bus.first_fail_valid), 64'd1);
    chk("sa0_pass", 64'(bus.pass), 64'd0);

    launch(0, 0, 1'b0, 64'd0);
    @(negedge clk);
    chk("nv0_done", 64'(bus.done), 64'd1);
    chk("nv0_pass", 64'(bus.pass), 64'd1);
    chk("nv0_busy", 64'(bus.busy), 64'd0);

    launch(40, 0, 1'b0, 64'd0);
    wait_k(50);
    poke_start();
    wait_k(96);
    chk("wrap_31", 64'(bus.x_out), 64'd31);
    wait_k(97);
    chk("wrap_0", 64'(bus.x_out), 64'd0);
    wait_done(500, k);
    chk("v40_lat", 64'(k), 64'd121);
    chk("v40_pass", 64'(bus.pass), 64'd1);

    launch(32, 2, 1'b0, 64'd0);
    wait_done(500, k);
    chk("sa1_err", 64'(bus.err_count), 64'd7);
    chk("sa1_ffv", 64'(bus.first_fail_vec), 64'd0);
    chk("sa1_pass", 64'(bus.pass), 64'd0);

    launch(32, 2, 1'b0, 64'd0);
    wait_k(30);
    #2;
    rst_n    = 1'b0;
    m_active = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    launch(10, 0, 1'b0, 64'd0);
    wait_done(500, k);
    chk("post_lat", 64'(k), 64'd31);
    chk("post_pass", 64'(bus.pass), 64'd1);

    launch(8, 0, 1'b1, 64'd0);
`ifdef MAJ_BIST_LFSR_EN
    chk("mode1_v0", 64'(bus.x_out), 64'd1);
    wait_k(4);
    chk("mode1_v1", 64'(bus.x_out), 64'd2);
`else
    chk("mode1_v0", 64'(bus.x_out), 64'd0);
    wait_k(4);
    chk("mode1_v1", 64'(bus.x_out), 64'd1);
`endif
    wait_done(500, k);
    chk("mode1_pass", 64'(bus.pass), 64'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maj_bist_ctrl.md
Name: maj_bist_ctrl

Overview:
- Sequential stimulus generator and response checker for the combinational N-input majority cells under test; the hardware counterpart of the popcount-reference bench.
- Drives an N-bit vector into a majority DUT, waits a settle interval, samples the DUT output and compares it with an internal popcount reference (ones >= THRESH).
- Accumulates a saturating error count, captures the first failing vector, and reports pass/fail once the run completes.

Parameters:
- N, 59, DUT input width.
- THRESH, (N+1)/2, reference threshold: ref = (popcount(x_out) >= THRESH).
- VW, 64, width of num_vectors and of the vector index counter.
- ERR_W, 16, err_count width; the count saturates at 2^ERR_W-1.
- SETTLE_CYC, 2, cycles between a vector being applied and its check (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- mode  in  1  0 = exhaustive counting, 1 = LFSR (only with MAJ_BIST_LFSR_EN).
- seed  in  64  LFSR seed, latched on an accepted start.
- num_vectors  in  VW  number of vectors to apply, latched on an accepted start.
- x_out  out  N  registered vector driven to the DUT.
- dut_y  in  1  DUT majority output.
- busy  out  1  high from the accepted start through the final CHECK.
- done  out  1  level; high in DONE until the next accepted start.
- pass  out  1  valid while done=1; 1 if err_count==0.
- err_count  out  ERR_W  number of mismatches, saturating.
- first_fail_vec  out  N  first mismatching vector.
- first_fail_valid  out  1  set on the first mismatch of a run.

Behaviour:
- Reset (async, rst_n=0) forces the FSM to IDLE and clears every output and internal counter: x_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
- States and transitions:
  - IDLE: on start, latch num_vectors, mode and seed, and clear err_count, first_fail_*, done and pass.
  - num_vectors==0: go to DONE on the next edge with pass=1.
  - Otherwise: load x_out, go to SETTLE and assert busy.
  - SETTLE: wait SETTLE_CYC cycles, then go to CHECK.
  - CHECK (exactly one cycle): compare dut_y with ref(x_out).
    - On mismatch: err_count+1 (held at its maximum once saturated). If first_fail_valid==0, capture x_out into first_fail_vec and set first_fail_valid.
    - Increment the index counter.
    - If index==num_vectors: go to DONE, deassert busy, set done, and set pass = (err_count after this update == 0).
    - Otherwise: advance x_out and return to SETTLE.
  - DONE: hold all results; a start here begins a new run (same actions as in IDLE).
- Throughput: each vector costs SETTLE_CYC+1 cycles. A run of V>0 vectors asserts done exactly 1+V*(SETTLE_CYC+1) cycles after the start edge.
- Exhaustive mode: the first vector is 0 and x_out increments by 1 mod 2^N. When num_vectors > 2^N, x_out wraps through all-ones to 0 and the run continues.
- The reference popcount is combinational on x_out, with a width of clog2(N+1).
- start while busy is ignored and has no effect on the run in progress.
- Reset mid-run aborts immediately, with no done and no result retention.
- The index counter is VW bits, so num_vectors = 2^VW-1 is the maximum run length.

Optional Feature:
- Macro: MAJ_BIST_LFSR_EN.
- Defined:
  - mode=1 selects a 64-bit Fibonacci LFSR, taps 64,63,61,60.
  - The LFSR loads seed on an accepted start; seed==0 is replaced by 1.
  - x_out = lfsr[N-1:0] (requires N <= 64).
  - The LFSR steps once per CHECK.
  - The first applied vector is the seed value.
- Undefined:
  - mode and seed are ignored; every run is exhaustive.
  - No LFSR logic is synthesized.

Test Plan:
- Exhaustive, N=5, THRESH=3, SETTLE_CYC=2, correct majority DUT, num_vectors=32, start -> done 97 cycles after start, pass=1, err_count=0, first_fail_valid=0.
- Same setup with dut_y stuck at 0 -> err_count=16, first_fail_vec=5'b00111, first_fail_valid=1, pass=0.
- num_vectors=0, start -> done=1 and pass=1 on the next edge, busy never asserted, err_count=0.
- num_vectors=40 with N=5 and a correct DUT -> x_out wraps from 31 to 0 at vector 33, pass=1, done after 121 cycles. Second start pulse mid-run -> ignored, same completion time.
- ERR_W=3 with a stuck-at-1 DUT, N=5, 32 vectors (16 mismatches) -> err_count saturates at 7, pass=0. Assert rst_n=0 mid-run -> all outputs 0 immediately; a new start then runs cleanly.
- MAJ_BIST_LFSR_EN defined, mode=1, seed=0 -> first x_out = 1, subsequent values follow the tap polynomial, correct DUT gives pass=1. Without the macro, mode=1 -> exhaustive sequence 0,1,2,...
